sm4_ck_seq: RTL and testbench

- Parametrised SM4 key-expansion CK round-constant sequencer; successor to the fixed 32-entry CK lookup.
- Generates CK_i for i=0..31 as a valid/ready stream, LANES constants per beat, for unrolled key-schedule engines.
- Supports forward order (encryption key schedule) and reverse order (decryption round-key regeneration).
- Sits between the key-schedule controller and the key-expansion datapath.

---
 rtl/sm4_pkg.sv | 19 +
 rtl/sm4_ck_calc.sv | 64 ++++++
 rtl/sm4_ck_seq.sv | 138 +++++++++++++
 tb/tb_sm4_ck_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 constants and the CK sequencer state encoding.
package sm4_pkg;

    localparam int SM4_ROUNDS  = 32;
    localparam int SM4_CK_STEP = 7;
    localparam int SM4_WORD_W  = 32;

    // Key-schedule FK constants, FK0..FK3.
    localparam logic [SM4_WORD_W-1:0] SM4_FK [4] = '{
        32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ck_seq_state_e;

endpackage

// File: rtl/sm4_ck_calc.sv
// Combinational SM4 CK constant for a 5-bit round index.
// Build option: SM4_CK_ROM_EN selects a 32-entry constant table;
// otherwise byte j of CK_i is (28*i + 7*j) mod 256.
module sm4_ck_calc
    import sm4_pkg::*;
(
    input  logic [4:0]            idx,
    output logic [SM4_WORD_W-1:0] ck
);

`ifdef SM4_CK_ROM_EN
    // Table lookup of the 32 CK constants.
    always_comb begin
        ck = '0;
        case (idx)
            5'd0:  ck = 32'h00070e15;
            5'd1:  ck = 32'h1c232a31;
            5'd2:  ck = 32'h383f464d;
            5'd3:  ck = 32'h545b6269;
            5'd4:  ck = 32'h70777e85;
            5'd5:  ck = 32'h8c939aa1;
            5'd6:  ck = 32'ha8afb6bd;
            5'd7:  ck = 32'hc4cbd2d9;
            5'd8:  ck = 32'he0e7eef5;
            5'd9:  ck = 32'hfc030a11;
            5'd10: ck = 32'h181f262d;
            5'd11: ck = 32'h343b4249;
            5'd12: ck = 32'h50575e65;
            5'd13: ck = 32'h6c737a81;
            5'd14: ck = 32'h888f969d;
            5'd15: ck = 32'ha4abb2b9;
            5'd16: ck = 32'hc0c7ced5;
            5'd17: ck = 32'hdce3eaf1;
            5'd18: ck = 32'hf8ff060d;
            5'd19: ck = 32'h141b2229;
            5'd20: ck = 32'h30373e45;
            5'd21: ck = 32'h4c535a61;
            5'd22: ck = 32'h686f767d;
            5'd23: ck = 32'h848b9299;
            5'd24: ck = 32'ha0a7aeb5;
            5'd25: ck = 32'hbcc3cad1;
            5'd26: ck = 32'hd8dfe6ed;
            5'd27: ck = 32'hf4fb0209;
            5'd28: ck = 32'h10171e25;
            5'd29: ck = 32'h2c333a41;
            5'd30: ck = 32'h484f565d;
            5'd31: ck = 32'h646b7279;
            default: ck = '0;
        endcase
    end
`else
    logic [7:0] byte0;

    // Byte 0 is 28*i in 8-bit wrap arithmetic; later bytes add 7 per byte.
    always_comb begin
        byte0 = {3'b000, idx} * 8'd28;
        ck    = {byte0,
                 byte0 + 8'(SM4_CK_STEP),
                 byte0 + 8'(2 * SM4_CK_STEP),
                 byte0 + 8'(3 * SM4_CK_STEP)};
    end
`endif

endmodule

// File: rtl/sm4_ck_seq.sv
// SM4 key-expansion CK round-constant sequencer: streams CK_0..CK_31
// (or CK_31..CK_0) as a valid/ready stream, LANES constants per beat.
// Build option: SM4_CK_ROM_EN (passed through to sm4_ck_calc).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// RUN     | presenting beats; base holds the lane-0 index of the next beat
// DONE    | one-cycle done pulse after the final handshake
module sm4_ck_seq
    import sm4_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        dir,
    input  logic                        abort,
    output logic                        ck_valid,
    input  logic                        ck_ready,
    output logic [SM4_WORD_W*LANES-1:0] ck_data,
    output logic [4:0]                  ck_round,
    output logic                        ck_last,
    output logic                        busy,
    output logic                        done
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8) ||
        (SM4_ROUNDS % LANES) != 0) begin : g_bad_lanes
        $error("sm4_ck_seq: LANES must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] STEP     = 5'(LANES);
    localparam logic [4:0] LAST_FWD = 5'(SM4_ROUNDS - LANES);
    localparam logic [4:0] LAST_REV = 5'(LANES - 1);

    ck_seq_state_e state_q, state_d;
    logic          dir_q, dir_d;
    logic [4:0]    base_q, base_d;
    logic          valid_d, last_d, busy_d, done_d;
    logic [4:0]    round_d;
    logic [SM4_WORD_W*LANES-1:0] data_d, lane_flat;
    logic          base_is_last;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [4:0] lane_idx;
        assign lane_idx = dir_q ? (base_q - 5'(k)) : (base_q + 5'(k));
        sm4_ck_calc u_calc (
            .idx (lane_idx),
            .ck  (lane_flat[SM4_WORD_W*k +: SM4_WORD_W])
        );
    end

    assign base_is_last = dir_q ? (base_q == LAST_REV) : (base_q == LAST_FWD);

    // Next-state and next registered-output values.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        base_d  = base_q;
        valid_d = ck_valid;
        data_d  = ck_data;
        round_d = ck_round;
        last_d  = ck_last;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dir_d   = dir;
                    base_d  = dir ? 5'd31 : 5'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    round_d = '0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (ck_valid && ck_ready && ck_last) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    round_d = '0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!ck_valid || ck_ready) begin
                    // First beat after start, or the current beat was taken.
                    valid_d = 1'b1;
                    data_d  = lane_flat;
                    round_d = base_q;
                    last_d  = base_is_last;
                    base_d  = dir_q ? (base_q - STEP) : (base_q + STEP);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            base_q   <= '0;
            ck_valid <= 1'b0;
            ck_data  <= '0;
            ck_round <= '0;
            ck_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            base_q   <= base_d;
            ck_valid <= valid_d;
            ck_data  <= data_d;
            ck_round <= round_d;
            ck_last  <= last_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_sm4_ck_seq.sv
// Directed bench for sm4_ck_seq with one LANES=1 and one LANES=4 instance.
module tb_sm4_ck_seq;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    logic start1 = 0, dir1 = 0, abort1 = 0, ready1 = 1;
    logic v1, l1, b1, dn1;
    logic [31:0] d1;
    logic [4:0]  r1;

    logic start4 = 0, dir4 = 0, abort4 = 0, ready4 = 1;
    logic v4, l4, b4, dn4;
    logic [127:0] d4;
    logic [4:0]   r4;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cap1 [32];

    always #5 clk_sys = ~clk_sys;

    sm4_ck_seq #(.LANES(1)) dut1 (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start1), .dir(dir1),
        .abort(abort1), .ck_valid(v1), .ck_ready(ready1), .ck_data(d1),
        .ck_round(r1), .ck_last(l1), .busy(b1), .done(dn1)
    );

    sm4_ck_seq #(.LANES(4)) dut4 (
        .clk_sys(clk_sys), .rst_n(rst_n), .start(start4), .dir(dir4),
        .abort(abort4), .ck_valid(v4), .ck_ready(ready4), .ck_data(d4),
        .ck_round(r4), .ck_last(l4), .busy(b4), .done(dn4)
    );

    function automatic logic [31:0] ck_model(input int i);
        logic [7:0] b;
        b = 8'((28 * i) & 255);
        return {b, b + 8'd7, b + 8'd14, b + 8'd21};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Full 32-beat run on the LANES=1 instance with continuous ready,
    // including an ignored start pulse (opposite dir) mid-stream.
    task automatic run1(input logic d);
        int idx;
        start1 = 1'b1; dir1 = d; ready1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("run1_busy_after_start", 128'(b1), 128'(1));
        check("run1_no_valid_yet", 128'(v1), 128'(0));
        for (int b = 0; b < 32; b++) begin
            tick();
            idx = d ? 31 - b : b;
            cap1[b] = d1;
            check("run1_valid", 128'(v1), 128'(1));
            check("run1_data", 128'(d1), 128'(ck_model(idx)));
            check("run1_round", 128'(r1), 128'(idx));
            check("run1_last", 128'(l1), 128'(b == 31));
            if (b == 3) begin start1 = 1'b1; dir1 = ~d; end
            else start1 = 1'b0;
        end
        tick();
        check("run1_done_pulse", 128'(dn1), 128'(1));
        check("run1_busy_low", 128'(b1), 128'(0));
        check("run1_valid_low", 128'(v1), 128'(0));
        tick();
        check("run1_done_once", 128'(dn1), 128'(0));
    endtask

    // Full 8-beat run on the LANES=4 instance.
    task automatic run4(input logic d);
        logic [127:0] exp;
        int base;
        start4 = 1'b1; dir4 = d; ready4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            tick();
            base = d ? 31 - 4 * b : 4 * b;
            for (int k = 0; k < 4; k++)
                exp[32*k +: 32] = ck_model(d ? base - k : base + k);
            check("run4_valid", 128'(v4), 128'(1));
            check("run4_data", d4, exp);
            check("run4_round", 128'(r4), 128'(base));
            check("run4_last", 128'(l4), 128'(b == 7));
            if (!d && b == 0) begin
                check("run4_b0_lane0", 128'(d4[31:0]), 128'(32'h00070e15));
                check("run4_b0_lane3", 128'(d4[127:96]), 128'(32'h545b6269));
            end
            if (!d && b == 7)
                check("run4_b7_lane3", 128'(d4[127:96]), 128'(32'h646b7279));
        end
        tick();
        check("run4_done", 128'(dn4), 128'(1));
        tick();
        check("run4_done_once", 128'(dn4), 128'(0));
    endtask

    initial begin
        int beat;
        int stall;
        int cyc;

        // Reset values
        rst_n = 1'b0;
        tick(); tick();
        check("rst_valid1", 128'(v1), 128'(0));
        check("rst_data1", 128'(d1), 128'(0));
        check("rst_round1", 128'(r1), 128'(0));
        check("rst_last1", 128'(l1), 128'(0));
        check("rst_busy1", 128'(b1), 128'(0));
        check("rst_done1", 128'(dn1), 128'(0));
        check("rst_valid4", 128'(v4), 128'(0));
        check("rst_data4", d4, 128'(0));
        rst_n = 1'b1;
        tick();

        // Forward and reverse on LANES=1
        run1(1'b0);
        check("fwd_beat0", 128'(cap1[0]), 128'(32'h00070e15));
        check("fwd_beat1", 128'(cap1[1]), 128'(32'h1c232a31));
        check("fwd_beat31", 128'(cap1[31]), 128'(32'h646b7279));
        run1(1'b1);
        check("rev_beat0", 128'(cap1[0]), 128'(32'h646b7279));
        check("rev_beat31", 128'(cap1[31]), 128'(32'h00070e15));

        // LANES=4 forward and reverse
        run4(1'b0);
        run4(1'b1);

        // Backpressure: ready low for 3 cycles while beat 5 is presented
        start1 = 1'b1; dir1 = 1'b0; ready1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        beat = 0; stall = 0; cyc = 0;
        while (beat < 32 && cyc < 60) begin
            check("bp_valid", 128'(v1), 128'(1));
            check("bp_data", 128'(d1), 128'(ck_model(beat)));
            check("bp_round", 128'(r1), 128'(beat));
            check("bp_last", 128'(l1), 128'(beat == 31));
            if (beat == 5 && stall > 0)
                check("bp_hold", 128'(d1), 128'(32'h8c939aa1));
            if (beat == 6)
                check("bp_resume", 128'(d1), 128'(32'ha8afb6bd));
            if (beat == 5 && stall < 3) begin
                ready1 = 1'b0;
                stall++;
            end else begin
                ready1 = 1'b1;
            end
            @(posedge clk_sys);
            if (ready1) beat++;
            cyc++;
            tick();
        end
        ready1 = 1'b1;
        check("bp_beats", 128'(beat), 128'(32));
        check("bp_cycles", 128'(cyc), 128'(35));
        check("bp_done", 128'(dn1), 128'(1));
        tick();

        // Abort on beat 10 together with a start pulse
        start1 = 1'b1; dir1 = 1'b0;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("ab_beat10", 128'(d1), 128'(ck_model(10)));
        abort1 = 1'b1; start1 = 1'b1; dir1 = 1'b1;
        tick();
        abort1 = 1'b0; start1 = 1'b0;
        check("ab_valid", 128'(v1), 128'(0));
        check("ab_busy", 128'(b1), 128'(0));
        check("ab_no_done", 128'(dn1), 128'(0));
        tick();
        check("ab_no_done2", 128'(dn1), 128'(0));
        check("ab_start_ignored", 128'(b1), 128'(0));
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("ab_idle_noeffect", 128'(b1), 128'(0));
        start1 = 1'b1; dir1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check("ab_restart_data", 128'(d1), 128'(32'h646b7279));
        check("ab_restart_round", 128'(r1), 128'(31));
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("ab_second_abort", 128'(v1), 128'(0));
        tick();

        // Asynchronous reset at beat 12
        start1 = 1'b1; dir1 = 1'b0;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check("rr_beat12", 128'(d1), 128'(ck_model(12)));
        #1 rst_n = 1'b0;
        #1;
        check("rr_valid", 128'(v1), 128'(0));
        check("rr_data", 128'(d1), 128'(0));
        check("rr_round", 128'(r1), 128'(0));
        check("rr_last", 128'(l1), 128'(0));
        check("rr_busy", 128'(b1), 128'(0));
        check("rr_done", 128'(dn1), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        start1 = 1'b1; dir1 = 1'b0;
        tick();
        start1 = 1'b0;
        tick();
        check("rr_first_beat", 128'(d1), 128'(32'h00070e15));
        check("rr_first_valid", 128'(v1), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
